// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with registered fetch; define IMEM_PARITY_EN for per-word parity
module imem_loadable #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 32,
  parameter logic [DATA_W-1:0] FILL = 8'b11000001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_end,
  output logic              load_done,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_oob,
  output logic              fetch_perr
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_n;
  logic [PTR_W-1:0] load_ptr;
  logic [DEPTH-1:0] written;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wdata, rword;
  logic [PTR_W-1:0] fidx;
  logic we, full, done_n, accept, in_range, hit, perr_n;
  assign load_ready = state == LOAD;
  assign busy = state == LOAD;
  assign fidx = fetch_addr[PTR_W-1:0];
`ifdef IMEM_PARITY_EN
  assign wdata = {^load_data, load_data};
  assign perr_n = hit && ^rword;
`else
  assign wdata = load_data;
  assign perr_n = 1'b0;
`endif
  // load sequencing and fetch qualification; a restart discards any same-cycle transfer
  always_comb begin
    full = load_ptr == PTR_W'(DEPTH - 1);
    we = (state == LOAD) && load_valid && !load_start;
    done_n = (state == LOAD) && !load_start && ((we && full) || load_end);
    state_n = load_start ? LOAD : done_n ? RUN : state;
    accept = (state == RUN) && fetch_req && !load_start;
    in_range = {1'b0, fetch_addr} < (ADDR_W + 1)'(DEPTH);
    rword = mem[fidx];
    hit = in_range && written[fidx];
  end
  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else state <= state_n;
  end
  // load pointer, written flags and one-cycle done pulse; pointer saturates at the last word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ptr <= '0;
      written <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= done_n;
      if (load_start) begin
        load_ptr <= '0;
        written <= '0;
      end else if (we) begin
        written[load_ptr] <= 1'b1;
        load_ptr <= full ? load_ptr : load_ptr + PTR_W'(1);
      end
    end
  end
  // storage array write port, contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[load_ptr] <= wdata;
  end
  // registered fetch result, held while no request is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_instr <= FILL;
      fetch_oob <= 1'b0;
      fetch_perr <= 1'b0;
    end else begin
      fetch_valid <= accept;
      if (accept) begin
        fetch_instr <= hit ? rword[DATA_W-1:0] : FILL;
        fetch_oob <= !hit;
        fetch_perr <= perr_n;
      end
    end
  end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: scoreboard bench for imem_loadable (default 8x32 config)
module tb_imem_loadable;
  localparam logic [7:0] FILL = 8'hC1;
  typedef struct packed {
    logic [7:0] instr;
    logic oob;
    logic perr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_start = 1'b0, load_valid = 1'b0, load_end = 1'b0, fetch_req = 1'b0;
  logic [7:0] load_data = '0, fetch_addr = '0;
  logic load_ready, load_done, busy, fetch_valid, fetch_oob, fetch_perr;
  logic [7:0] fetch_instr;
  exp_t q[$];
  logic [7:0] m_mem [32];
  logic m_wr [32];
  logic m_bad [32];
  int m_ptr = 0;
  int n_cmp = 0;
  int n_err = 0;
  imem_loadable dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_end(load_end),
    .load_done(load_done), .busy(busy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_oob(fetch_oob),
    .fetch_perr(fetch_perr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_model();
    m_ptr = 0;
    for (int i = 0; i < 32; i++) begin
      m_wr[i] = 1'b0;
      m_bad[i] = 1'b0;
    end
  endtask
  task automatic fetch(input logic [7:0] a);
    exp_t e;
    logic w;
    w = (a < 8'd32) && m_wr[a[4:0]];
    e.instr = w ? m_mem[a[4:0]] : FILL;
    e.oob = !w;
    e.perr = w && m_bad[a[4:0]];
    q.push_back(e);
    fetch_req = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask
  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    clear_model();
  endtask
  task automatic load_word(input logic [7:0] d, input logic e);
    chk("load_ready", load_ready, 1);
    chk("done_low", load_done, 0);
    load_valid = 1'b1;
    load_data = d;
    load_end = e;
    m_mem[m_ptr] = d;
    m_wr[m_ptr] = 1'b1;
    m_bad[m_ptr] = 1'b0;
    m_ptr++;
    tick();
    load_valid = 1'b0;
    load_end = 1'b0;
  endtask
  // scoreboard: every valid fetch result must match the oldest expectation
  always @(negedge clk) begin
    if (fetch_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("fetch_instr", fetch_instr, e.instr);
        chk("fetch_oob", fetch_oob, e.oob);
        chk("fetch_perr", fetch_perr, e.perr);
      end
    end
  end
  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fvalid", fetch_valid, 0);
    chk("rst_finstr", fetch_instr, FILL);
    chk("rst_foob", fetch_oob, 0);
    chk("rst_fperr", fetch_perr, 0);
    reset = 1'b0;
    tick();
    fetch(8'h00);
    chk("t1_busy", busy, 0);
    start_load();
    for (int i = 0; i < 32; i++) load_word(8'(i), 1'b0);
    chk("t2_done", load_done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_ready", load_ready, 0);
    fetch(8'h05);
    chk("t2_done_pulse", load_done, 0);
    fetch(8'h1F);
    fetch(8'h20);
    start_load();
    load_word(8'hA0, 1'b0);
    load_word(8'hA1, 1'b0);
    load_word(8'hA2, 1'b1);
    chk("t3_done", load_done, 1);
    chk("t3_busy", busy, 0);
    fetch(8'h02);
    fetch(8'h03);
    fetch(8'h40);
    fetch(8'hFF);
    load_start = 1'b1;
    fetch_req = 1'b1;
    fetch_addr = 8'h00;
    tick();
    load_start = 1'b0;
    fetch_req = 1'b0;
    clear_model();
    chk("t4_busy", busy, 1);
    chk("t4_drop", fetch_valid, 0);
    fetch_req = 1'b1;
    fetch_addr = 8'h01;
    for (int i = 0; i < 4; i++) load_word(8'hB0 + 8'(i), 1'b0);
    fetch_req = 1'b0;
    chk("t4_ld_fetch_ign", fetch_valid, 0);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hEE;
    load_end = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_end = 1'b0;
    clear_model();
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_nodone", load_done, 0);
    load_word(8'hC0, 1'b0);
    load_word(8'hC1, 1'b1);
    chk("t4_done", load_done, 1);
    fetch(8'h00);
    fetch(8'h01);
    fetch(8'h02);
    fetch(8'h03);
    start_load();
    for (int i = 0; i < 10; i++) load_word(8'h50 + 8'(i), 1'b0);
    reset = 1'b1;
    #1;
    clear_model();
    chk("t5_ready", load_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", load_done, 0);
    chk("t5_fvalid", fetch_valid, 0);
    chk("t5_finstr", fetch_instr, FILL);
    chk("t5_foob", fetch_oob, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    fetch(8'h00);
    fetch(8'h05);
    start_load();
    load_word(8'hD0, 1'b0);
    load_word(8'hD1, 1'b0);
    load_word(8'h7F, 1'b1);
`ifdef IMEM_PARITY_EN
    dut.mem[1][8] = ~dut.mem[1][8];
    m_bad[1] = 1'b1;
`endif
    fetch(8'h00);
    fetch(8'h01);
    fetch(8'h02);
    fetch(8'h09);
    tick();
    tick();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory. Successor to the fixed 32x8 combinational ROM.
- Width, depth and fill word are parameters. Contents are loaded at run time over a valid/ready stream.
- Fetch path: registered, one cycle latency; flags out-of-range and unwritten addresses.
- Sits between the program loader (testbench or UART front end) and the CPU fetch stage.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 8, fetch address width; must satisfy 2^ADDR_W >= DEPTH
DEPTH, 32, number of words stored (>=2)
FILL, 8'b11000001, word returned for out-of-range or unwritten addresses (DATA_W bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
load_start  in  1  begin (or restart) program load
load_valid  in  1  load_data is valid
load_ready  out  1  block accepts a load word this cycle
load_data  in  DATA_W  program word
load_end  in  1  terminate load early
load_done  out  1  one-cycle pulse after a load finishes
busy  out  1  1 while in LOAD
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  fetch address
fetch_valid  out  1  fetch result valid
fetch_instr  out  DATA_W  fetched instruction
fetch_oob  out  1  address >= DEPTH or word unwritten
fetch_perr  out  1  parity error on fetched word

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - state = RUN, load_ptr = 0, all per-word written bits = 0.
  - load_ready = 0, load_done = 0, busy = 0.
  - fetch_valid = 0, fetch_instr = FILL, fetch_oob = 0, fetch_perr = 0.
  - Memory array contents are not reset.
- States: RUN, LOAD. busy = (state==LOAD). load_ready = (state==LOAD), decoded combinationally from state.
- RUN, load_start=1:
  - Next state LOAD.
  - load_ptr <= 0; all written bits cleared in the same edge.
  - A fetch_req in the same cycle is dropped: fetch_valid=0 next cycle.
- RUN, fetch_req=1, load_start=0: next cycle fetch_valid=1 and
  - fetch_addr >= DEPTH (full-width compare): fetch_instr=FILL, fetch_oob=1.
  - In range but written bit = 0: fetch_instr=FILL, fetch_oob=1.
  - Otherwise: fetch_instr=mem[fetch_addr], fetch_oob=0.
- Fetch timing:
  - fetch_valid is 0 in any cycle following a cycle with no accepted request.
  - fetch_instr / fetch_oob hold their last value when fetch_valid=0.
  - Back-to-back requests give back-to-back results.
- LOAD, transfer (load_valid & load_ready):
  - mem[load_ptr] <= load_data; written[load_ptr] <= 1; load_ptr++.
- LOAD exits to RUN, with load_done=1 for exactly one cycle, on the edge when:
  - a transfer occurs with load_ptr==DEPTH-1 (array full), or
  - load_end=1. A transfer in the same cycle is written first.
- load_ptr never wraps; a full array always exits LOAD.
- LOAD, load_start=1: restart. load_ptr<=0, written bits cleared, and any same-cycle transfer is discarded. Takes priority over load_end.
- LOAD, fetch_req: ignored, fetch_valid=0.
- Fetch in the cycle after LOAD exits is served normally and sees the newly written data.
- Reset mid-load: immediate return to reset values; the partial program is invalidated (written bits cleared).

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from load_data at write.
  - On a fetch of a written, in-range word, parity is recomputed; mismatch sets fetch_perr=1 alongside fetch_valid.
  - fetch_perr=0 for FILL results.
- Not defined: no parity storage; fetch_perr tied to 0.

Test Plan:
- Reset, then fetch addr 0 -> fetch_valid=1 one cycle later, fetch_instr=8'hC1, fetch_oob=1, busy=0.
- load_start; stream 32 words 8'h00..8'h1F with load_valid held -> load_ready=1 for 32 cycles, load_done pulse once, busy falls; fetch addr 5 -> 8'h05, oob=0.
- Load 3 words 8'hA0,8'hA1,8'hA2 with load_end on the third -> load_done; fetch 2 -> 8'hA2; fetch 3 -> FILL, oob=1; fetch 8'h40 -> FILL, oob=1.
- load_start and fetch_req in the same cycle -> fetch_valid=0 next cycle, busy=1; load_start mid-load after 4 words -> ptr restarts, earlier words read as unwritten.
- Assert reset after 10 load words -> all outputs at reset values; fetch 0 -> FILL, oob=1.
- IMEM_PARITY_EN defined: force a flipped stored parity bit at addr 1, fetch 1 -> fetch_perr=1; clean words -> 0. Macro undefined -> fetch_perr always 0.
